// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory bus, with a fetch starvation guard and a bus-wait timeout.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic        mem_ack_o,
  output logic [31:0] mem_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  localparam int unsigned   SW           = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_BUSY = 2'd1, MEM_BUSY = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_wait;
  logic [SW-1:0] r_starve;
  logic          r_bus_req, r_bus_we, r_if_ack, r_mem_ack, r_err;
  logic [31:0]   r_bus_addr, r_bus_wdata, r_if_rdata, r_mem_rdata;
  logic [3:0]    r_bus_sel;

  logic w_busy, w_arb_ok, w_grant_mem, w_grant_if, w_done, w_timeout;
  logic w_if_ack_d, w_mem_ack_d;

  // No grant while an ack is out: the completing master needs that cycle to
  // present its next request, so both masters then compete on equal terms.
  assign w_arb_ok    = (r_state == IDLE) & ~r_if_ack & ~r_mem_ack;
  assign w_grant_mem = w_arb_ok & mem_req_i & (~if_req_i | (r_starve != STARVE_MAX));
  assign w_grant_if  = w_arb_ok & if_req_i & ~w_grant_mem;
  assign w_busy      = (r_state != IDLE);
  assign w_done      = w_busy & bus_ack_i;
  // Abort at the end of the TIMEOUT-th ack-less busy cycle; a late ack wins.
  assign w_timeout   = w_busy & ~bus_ack_i & (r_wait == TIMEOUT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // NOTE: default assignment first so no path leaves w_next unassigned (latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_mem)     w_next = MEM_BUSY;
        else if (w_grant_if) w_next = IF_BUSY;
      end
      IF_BUSY, MEM_BUSY: begin
        if (w_done || w_timeout) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_if_ack_d  = 1'b0;
    w_mem_ack_d = 1'b0;
    if (w_done || w_timeout) begin
      w_if_ack_d  = (r_state == IF_BUSY);
      w_mem_ack_d = (r_state == MEM_BUSY);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_sel   <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_err       <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_wait      <= '0;
      r_starve    <= '0;
    end else begin
      r_bus_req <= (w_next != IDLE);
      r_if_ack  <= w_if_ack_d;
      r_mem_ack <= w_mem_ack_d;
      r_err     <= w_timeout;

      if (w_grant_mem) begin
        r_bus_we    <= mem_we_i;
        r_bus_addr  <= mem_addr_i;
        r_bus_wdata <= mem_wdata_i;
        r_bus_sel   <= mem_sel_i;
      end else if (w_grant_if) begin
        r_bus_we    <= 1'b0;
        r_bus_addr  <= if_addr_i;
        r_bus_wdata <= '0;
        r_bus_sel   <= 4'hF;
      end

      if (w_if_ack_d)  r_if_rdata  <= w_done ? bus_rdata_i : '0;
      if (w_mem_ack_d) r_mem_rdata <= (w_done && !r_bus_we) ? bus_rdata_i : '0;

      if (w_grant_mem || w_grant_if)  r_wait <= '0;
      else if (w_busy && !bus_ack_i)  r_wait <= r_wait + 8'd1;

      if (w_grant_if)
        r_starve <= '0;
      else if (w_grant_mem && if_req_i && (r_starve != STARVE_MAX))
        r_starve <= r_starve + 1'b1;
    end
  end

  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_sel_o   = r_bus_sel;
  assign if_ack_o    = r_if_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_ack_o   = r_mem_ack;
  assign mem_rdata_o = r_mem_rdata;
  assign bus_err_o   = r_err;
  assign stallreq_o  = (if_req_i & ~r_if_ack) | (mem_req_i & ~r_mem_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: per-feature tasks plus an ack
// monitor that pops a scoreboard of expected completions.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, bus_ack_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i, bus_rdata_i;
  logic [3:0]  mem_sel_i;
  logic        if_ack_o, mem_ack_o, bus_req_o, bus_we_o, stallreq_o, bus_err_o;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_sel_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Completion monitor: every ack pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_ack_o || mem_ack_o) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ack: if_ack=%0b mem_ack=%0b, required no ack", if_ack_o, mem_ack_o);
      end else begin
        exp_t e;
        logic [31:0] got;
        e   = sb.pop_front();
        got = e.is_mem ? mem_rdata_o : if_rdata_o;
        if (if_ack_o !== ~e.is_mem || mem_ack_o !== e.is_mem || got !== e.rdata || bus_err_o !== e.err) begin
          n_errors++;
          $display("FAIL completion: if_ack=%0b mem_ack=%0b rdata=%h err=%0b, required is_mem=%0b rdata=%h err=%0b",
                   if_ack_o, mem_ack_o, got, bus_err_o, e.is_mem, e.rdata, e.err);
        end
      end
    end else if (bus_err_o !== 1'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL err_without_ack: bus_err=%0b, required 0", bus_err_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    if_req_i = 0; if_addr_i = '0; mem_req_i = 0; mem_we_i = 0;
    mem_addr_i = '0; mem_wdata_i = '0; mem_sel_i = '0;
    bus_ack_i = 0; bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    sample();
    n_checks++;
    if ({bus_req_o, bus_we_o, if_ack_o, mem_ack_o, bus_err_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: req/we/if_ack/mem_ack/err=%b, required 00000",
               {bus_req_o, bus_we_o, if_ack_o, mem_ack_o, bus_err_o});
    end
    n_checks++;
    if (bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_sel_o !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h sel=%h, required all 0", bus_addr_o, bus_wdata_o, bus_sel_o);
    end
    n_checks++;
    if (if_rdata_o !== 32'h0 || mem_rdata_o !== 32'h0 || stallreq_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_data: if_rdata=%h mem_rdata=%h stall=%0b, required 0", if_rdata_o, mem_rdata_o, stallreq_o);
    end
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_if_read();
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h0000_0100;
    sb.push_back('{is_mem: 1'b0, rdata: 32'hDEAD_BEEF, err: 1'b0});
    sample();
    n_checks++;
    if (stallreq_o !== 1'b1 || bus_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL if_read_req_cycle: stall=%0b bus_req=%0b, required 1 0", stallreq_o, bus_req_o);
    end
    next_cycle();
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF || stallreq_o !== 1'b1) begin
      n_errors++;
      $display("FAIL if_read_grant: req=%0b addr=%h we=%0b sel=%h stall=%0b, required 1 00000100 0 f 1",
               bus_req_o, bus_addr_o, bus_we_o, bus_sel_o, stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'hDEAD_BEEF;
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h100) begin
      n_errors++;
      $display("FAIL if_read_stable: req=%0b addr=%h, required 1 00000100", bus_req_o, bus_addr_o);
    end
    next_cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    n_checks++;
    if (if_ack_o !== 1'b1 || stallreq_o !== 1'b0 || bus_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL if_read_ack_cycle: if_ack=%0b stall=%0b bus_req=%0b, required 1 0 0", if_ack_o, stallreq_o, bus_req_o);
    end
    next_cycle();
    if_req_i = 0;
    sample();
    n_checks++;
    if (if_ack_o !== 1'b0 || if_rdata_o !== 32'hDEAD_BEEF || bus_req_o !== 1'b0) begin
      n_errors++;
      $display("FAIL if_read_after: if_ack=%0b rdata=%h bus_req=%0b, required 0 deadbeef 0", if_ack_o, if_rdata_o, bus_req_o);
    end
  endtask

  task automatic test_store();
    next_cycle();
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h10; mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'b0011;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h0, err: 1'b0});
    sample();
    n_checks++;
    if (stallreq_o !== 1'b1) begin
      n_errors++;
      $display("FAIL store_stall: stall=%0b, required 1", stallreq_o);
    end
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'hFFFF_FFFF;
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b1 || bus_addr_o !== 32'h10 || bus_wdata_o !== 32'h1234_5678 || bus_sel_o !== 4'b0011) begin
      n_errors++;
      $display("FAIL store_bus: req=%0b we=%0b addr=%h wdata=%h sel=%b, required 1 1 00000010 12345678 0011",
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o);
    end
    next_cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    n_checks++;
    if (mem_ack_o !== 1'b1 || stallreq_o !== 1'b0) begin
      n_errors++;
      $display("FAIL store_ack_latency: mem_ack=%0b stall=%0b, required 1 0", mem_ack_o, stallreq_o);
    end
    next_cycle();
    mem_req_i = 0; mem_we_i = 0;
    sample();
    n_checks++;
    if (mem_ack_o !== 1'b0) begin
      n_errors++;
      $display("FAIL store_ack_pulse: mem_ack=%0b, required 0", mem_ack_o);
    end
  endtask

  task automatic test_bus_ack_idle();
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_checks++;
      if (bus_req_o !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_ack_ignored: bus_req=%0b cycle %0d, required 0", bus_req_o, c);
      end
      next_cycle();
    end
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    n_checks++;
    if (if_rdata_o !== 32'hDEAD_BEEF || mem_rdata_o !== 32'h0) begin
      n_errors++;
      $display("FAIL rdata_hold: if_rdata=%h mem_rdata=%h, required deadbeef 00000000", if_rdata_o, mem_rdata_o);
    end
  endtask

  task automatic test_mem_load();
    next_cycle();
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h20; mem_sel_i = 4'hC;
    sb.push_back('{is_mem: 1'b1, rdata: 32'hCAFE_F00D, err: 1'b0});
    next_cycle();
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_we_o !== 1'b0 || bus_addr_o !== 32'h20 || bus_sel_o !== 4'hC) begin
      n_errors++;
      $display("FAIL load_bus: req=%0b we=%0b addr=%h sel=%h, required 1 0 00000020 c", bus_req_o, bus_we_o, bus_addr_o, bus_sel_o);
    end
    repeat (2) next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_F00D;
    next_cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    next_cycle();
    mem_req_i = 0;
    sample();
  endtask

  task automatic test_contention();
    logic [5:0] pattern;
    logic       found, is_mem;
    pattern = 6'b101111;
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h200;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    for (int g = 0; g < 6; g++) begin
      found = 0;
      for (int c = 0; c < 8; c++) begin
        sample();
        if (bus_req_o === 1'b1) begin
          found = 1;
          break;
        end
        next_cycle();
      end
      n_checks++;
      if (!found) begin
        n_errors++;
        $display("FAIL contention_grant_wait: no grant %0d within 8 cycles, required grant", g);
        break;
      end
      is_mem = pattern[g];
      n_checks++;
      if (bus_addr_o !== (is_mem ? 32'h300 : 32'h200)) begin
        n_errors++;
        $display("FAIL contention_order: grant %0d addr=%h, required %h", g, bus_addr_o, is_mem ? 32'h300 : 32'h200);
      end
      sb.push_back('{is_mem: is_mem, rdata: 32'hA000_0000 + 32'(g), err: 1'b0});
      next_cycle();
      bus_ack_i = 1; bus_rdata_i = 32'hA000_0000 + 32'(g);
      next_cycle();
      bus_ack_i = 0; bus_rdata_i = '0;
      if (g == 5) begin
        if_req_i = 0;
        mem_req_i = 0;
      end
    end
    if_req_i = 0; mem_req_i = 0;
    sample();
  endtask

  task automatic test_timeout();
    int   busy;
    logic done;
    busy = 0; done = 0;
    next_cycle();
    if_req_i = 1; if_addr_i = 32'h500; bus_rdata_i = 32'h5555_5555;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0, err: 1'b1});
    for (int c = 0; c < 400; c++) begin
      sample();
      if (bus_req_o === 1'b1) busy++;
      else if (busy > 0) begin
        done = 1;
        break;
      end
      next_cycle();
    end
    n_checks++;
    if (!done || busy != 255) begin
      n_errors++;
      $display("FAIL timeout_wait_cycles: bus_req high %0d cycles (dropped=%0b), required 255", busy, done);
    end
    n_checks++;
    if (bus_err_o !== 1'b1 || if_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_pulse: err=%0b if_ack=%0b, required 1 1", bus_err_o, if_ack_o);
    end
    next_cycle();
    if_req_i = 0; bus_rdata_i = '0;
    sample();
    n_checks++;
    if (bus_err_o !== 1'b0 || bus_req_o !== 1'b0 || if_rdata_o !== 32'h0) begin
      n_errors++;
      $display("FAIL timeout_after: err=%0b bus_req=%0b if_rdata=%h, required 0 0 00000000", bus_err_o, bus_req_o, if_rdata_o);
    end
  endtask

  task automatic test_timeout_ack_late();
    next_cycle();
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h600; mem_sel_i = 4'hF;
    sb.push_back('{is_mem: 1'b1, rdata: 32'h7777_0001, err: 1'b0});
    next_cycle();
    repeat (254) next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'h7777_0001;
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1) begin
      n_errors++;
      $display("FAIL late_ack_still_busy: bus_req=%0b in wait cycle 255, required 1", bus_req_o);
    end
    next_cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    n_checks++;
    if (mem_ack_o !== 1'b1 || bus_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL late_ack_wins: mem_ack=%0b err=%0b, required 1 0", mem_ack_o, bus_err_o);
    end
    next_cycle();
    mem_req_i = 0;
    sample();
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 0;
    next_cycle();
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h700; mem_wdata_i = 32'h99; mem_sel_i = 4'hF;
    if_req_i = 1; if_addr_i = 32'h400;
    next_cycle();
    sample();
    n_checks++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h700) begin
      n_errors++;
      $display("FAIL rst_mid_setup: bus_req=%0b addr=%h, required 1 00000700", bus_req_o, bus_addr_o);
    end
    #2;
    rst = 0; mem_req_i = 0; mem_we_i = 0;
    #1;
    n_checks++;
    if ({bus_req_o, bus_we_o, mem_ack_o, if_ack_o, bus_err_o} !== 5'b0 ||
        bus_addr_o !== 32'h0 || bus_wdata_o !== 32'h0 || bus_sel_o !== 4'h0) begin
      n_errors++;
      $display("FAIL rst_mid_async: req/we/mem_ack/if_ack/err=%b addr=%h wdata=%h sel=%h, required all 0",
               {bus_req_o, bus_we_o, mem_ack_o, if_ack_o, bus_err_o}, bus_addr_o, bus_wdata_o, bus_sel_o);
    end
    repeat (2) begin
      next_cycle();
      sample();
    end
    next_cycle();
    rst = 1;
    sb.push_back('{is_mem: 1'b0, rdata: 32'h0BAD_F00D, err: 1'b0});
    for (int c = 0; c < 8; c++) begin
      sample();
      if (bus_req_o === 1'b1) begin
        found = 1;
        break;
      end
      next_cycle();
    end
    n_checks++;
    if (!found || bus_addr_o !== 32'h400 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF) begin
      n_errors++;
      $display("FAIL rst_mid_regrant: found=%0b addr=%h we=%0b sel=%h, required 1 00000400 0 f",
               found, bus_addr_o, bus_we_o, bus_sel_o);
    end
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'h0BAD_F00D;
    next_cycle();
    bus_ack_i = 0; bus_rdata_i = '0;
    sample();
    next_cycle();
    if_req_i = 0;
    sample();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store();
    test_bus_ack_idle();
    test_mem_load();
    test_contention();
    test_timeout();
    test_timeout_ack_late();
    test_reset_mid();
    repeat (2) next_cycle();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d completions outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive MEM grants while IF waits.
REQ-002 SHALL have parameter TIMEOUT, default 255: bus wait cycles before abort (8-bit).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_req_i in 1, if_addr_i in 32: fetch read request and address.
REQ-006 SHALL have ports if_ack_o out 1, if_rdata_o out 32: fetch completion pulse and data.
REQ-007 SHALL have ports mem_req_i in 1, mem_we_i in 1, mem_addr_i in 32, mem_wdata_i in 32, mem_sel_i in 4: load/store request.
REQ-008 SHALL have ports mem_ack_o out 1, mem_rdata_o out 32: load/store completion pulse and load data.
REQ-009 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_wdata_o out 32, bus_sel_o out 4: shared memory port.
REQ-010 SHALL have ports bus_ack_i in 1, bus_rdata_i in 32: memory completion and read data.
REQ-011 SHALL have ports stallreq_o out 1 (pipeline stall), bus_err_o out 1 (timeout pulse).

Function
REQ-012 SHALL use FSM states IDLE, IF_BUSY, MEM_BUSY.
REQ-013 In IDLE, with only mem_req_i high: latch MEM address/we/wdata/sel into bus registers, go MEM_BUSY at next edge.
REQ-014 In IDLE, with only if_req_i high: latch if_addr_i, bus_we_o=0, bus_sel_o=4'hF, go IF_BUSY.
REQ-015 In IDLE, both high: grant MEM unless starve counter == STARVE_LIMIT, then grant IF.
REQ-016 Starve counter SHALL increment on each MEM grant made while if_req_i high, clear on any IF grant, saturate at STARVE_LIMIT.
REQ-017 bus_req_o SHALL be high exactly in IF_BUSY and MEM_BUSY; bus_* outputs SHALL be registered and stable for the whole access.
REQ-018 On bus_ack_i high in a BUSY state: register bus_rdata_i into granted requester's rdata_o, pulse its ack_o for one cycle on next cycle, return to IDLE.
REQ-019 For MEM writes, mem_rdata_o SHALL be 0 on completion.
REQ-020 Requester SHALL hold req and operands until ack; arbiter SHALL ignore a requester's req in the cycle its ack_o is high.
REQ-021 Latency: req sampled in IDLE at edge k -> bus_req_o high from k; bus_ack_i in cycle n -> ack_o high in cycle n+1; minimum 2 cycles req-to-ack.
REQ-022 bus_ack_i in IDLE SHALL be ignored.
REQ-023 Wait counter SHALL clear on entering a BUSY state and increment each BUSY cycle without bus_ack_i.
REQ-024 When wait counter reaches TIMEOUT without bus_ack_i: drop bus_req_o, pulse granted ack_o with rdata 0, pulse bus_err_o one cycle, return to IDLE.
REQ-025 bus_ack_i in the same cycle as timeout SHALL win: normal completion, no bus_err_o.
REQ-026 stallreq_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-027 if_rdata_o/mem_rdata_o SHALL hold last value between accesses.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, all counters 0, bus_req_o/bus_we_o/ack_o/bus_err_o 0, all data/address outputs 0, bus_sel_o 0.
REQ-029 Reset mid-access SHALL abandon the access with no ack_o pulse; first grant after release follows REQ-013..015.

Verification
REQ-030 IF read: if_req_i, addr 0x0000_0100, bus_ack_i after 2 cycles with 0xDEAD_BEEF -> one if_ack_o pulse, if_rdata_o 0xDEAD_BEEF, bus_we_o 0.
REQ-031 Store: mem_we_i=1, addr 0x10, wdata 0x1234_5678, sel 4'b0011 -> bus outputs match exactly; mem_ack_o pulse, mem_rdata_o 0.
REQ-032 Contention: both req held, MEM re-requesting continuously -> 4 MEM grants then IF grant; counter cleared.
REQ-033 Timeout: bus_ack_i never asserted -> after 255 wait cycles bus_err_o and ack_o pulse, rdata 0, FSM IDLE; ack at cycle 255 -> no error.
REQ-034 Reset: rst low while MEM_BUSY -> outputs zero immediately, no mem_ack_o; after release pending if_req_i granted.
REQ-035 stallreq_o high every cycle a req is pending without ack, low in ack cycle.
